param_stall_pipe: RTL and testbench

Parametrised in-order instruction pipeline with per-stage valid bits and a valid/ready handshake at both ends. It is the generalised successor of the fixed 4-stage stalling datapath.
- Depth and data width are parameters.
- Supports output back-pressure, bubble collapsing, an external stall, a multi-cycle hold for a designated opcode, a synchronous flush, and a saturating stall-cycle counter.
- Sits between instruction fetch and writeback.

---
 rtl/param_stall_pipe_if.sv | 22 ++
 rtl/param_stall_pipe.sv | 115 +++++++++++
 tb/tb_param_stall_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_stall_pipe_if.sv
// Instruction handshake bundle for param_stall_pipe: upstream valid/ready/data
// and downstream valid/ready/data. The master drives instructions in and accepts results.
interface param_stall_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/param_stall_pipe.sv
// In-order DEPTH-stage instruction pipe with bubble collapsing, external stall,
// opcode-triggered hold in S0, synchronous flush and a saturating stall counter.
module param_stall_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        v_q <= 1'b0;
    else if (flush) v_q <= 1'b0;
    else if (load)  v_q <= v_in;
  end

  // Data is not reset; a bubble's payload is don't-care.
  always_ff @(posedge clk) begin
    if (load) d_q <= d_in;
  end
endmodule

module param_stall_pipe #(
  parameter int             WIDTH     = 32,
  parameter int             DEPTH     = 4,
  parameter int             OPW       = 4,
  parameter logic [OPW-1:0] STALL_OP  = 4'hF,
  parameter int             STALL_CYC = 3,
  parameter int             CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  param_stall_pipe_if.slave    bus,
  input  logic                 ext_stall,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNTW-1:0]      stall_count
);
  localparam int HW = (STALL_CYC < 1) ? 1 : $clog2(STALL_CYC + 1);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]              rdy;
  logic [DEPTH-1:0]            stg_load;
  logic [DEPTH-1:0]            stg_vin;
  logic [DEPTH-1:0][WIDTH-1:0] stg_din;
  logic                        adv0;
  logic                        acc;
  logic                        is_hold_op;
  logic [HW-1:0]               hold_cnt;

  // Ready chain from the output back: an empty stage always accepts.
  assign rdy[DEPTH] = bus.out_ready;
  assign adv0       = rdy[1] && (hold_cnt == '0) && !ext_stall;
  assign rdy[0]     = !vld_pipe[0] || adv0;

  assign bus.in_ready = rdy[0] && !ext_stall && !flush;
  assign acc          = bus.in_valid && bus.in_ready;
  assign is_hold_op   = (bus.in_data[WIDTH-1 -: OPW] == STALL_OP);

  // S0 refills whenever it is free and not externally frozen; in_valid=0 makes a bubble.
  assign stg_load[0] = rdy[0] && !ext_stall;
  assign stg_vin[0]  = bus.in_valid;
  assign stg_din[0]  = bus.in_data;

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_chain
      assign rdy[i]      = !vld_pipe[i] || rdy[i+1];
      assign stg_load[i] = rdy[i];
      assign stg_din[i]  = dat_pipe[i-1];
      if (i == 1) begin : g_s1
        assign stg_vin[i] = vld_pipe[0] && adv0;
      end else begin : g_sn
        assign stg_vin[i] = vld_pipe[i-1];
      end
    end

    for (i = 0; i < DEPTH; i++) begin : g_stage
      param_stall_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (stg_load[i]),
        .v_in  (stg_vin[i]),
        .d_in  (stg_din[i]),
        .v_q   (vld_pipe[i]),
        .d_q   (dat_pipe[i])
      );
    end
  endgenerate

  // Hold loads only as the instruction is written into S0, so it is never re-armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       hold_cnt <= '0;
    else if (flush)                                hold_cnt <= '0;
    else if (acc && is_hold_op && STALL_CYC != 0)  hold_cnt <= HW'(STALL_CYC);
    else if (hold_cnt != '0)                       hold_cnt <= hold_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (bus.in_valid && !bus.in_ready && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

  assign busy         = |vld_pipe;
  assign bus.out_valid = vld_pipe[DEPTH-1] && !flush;
  assign bus.out_data  = dat_pipe[DEPTH-1];
endmodule

// File: tb/tb_param_stall_pipe.sv
// Randomised and directed bench for param_stall_pipe against an item-level slot model.
module tb_param_stall_pipe;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_stall = 1'b0;
  logic          flush = 1'b0;
  logic          busy;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  param_stall_pipe_if #(.WIDTH(W)) bus ();

  param_stall_pipe #(
    .WIDTH(W), .DEPTH(D), .OPW(4), .STALL_OP(4'hF), .STALL_CYC(3), .CNTW(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ext_stall   (ext_stall),
    .flush       (flush),
    .busy        (busy),
    .stall_count (stall_count)
  );

  // Model: slots holding instructions, a hold timer and a saturating counter.
  bit         mv[D];
  logic [W-1:0] md[D];
  bit         mmove[D];
  int         mhold, mcnt;
  bit         m_inrdy, m_ovld, last_acc;
  int         cyc_n;
  logic [W-1:0] ret_q[$];
  int         ret_t[$], acc_t[$];
  int         compared = 0, mismatched = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_clear();
    foreach (mv[k]) mv[k] = 1'b0;
    mhold = 0;
    mcnt  = 0;
  endtask

  task automatic clear_logs();
    ret_q.delete(); ret_t.delete(); acc_t.delete();
  endtask

  // Which items move this cycle: an item moves if the slot ahead ends up free.
  task automatic model_eval();
    bit free;
    free = !mv[D-1] || bus.out_ready;
    mmove[D-1] = mv[D-1] && bus.out_ready;
    for (int k = D-2; k >= 0; k--) begin
      mmove[k] = mv[k] && free && (k != 0 || (mhold == 0 && !ext_stall));
      free = !mv[k] || mmove[k];
    end
    m_inrdy = free && !ext_stall && !flush;
    m_ovld  = mv[D-1] && !flush;
  endtask

  task automatic model_step();
    bit         nv[D];
    logic [W-1:0] nd[D];
    last_acc = bus.in_valid && m_inrdy;
    if (bus.in_valid && !m_inrdy && mcnt < (1 << CW) - 1) mcnt++;
    if (flush) begin
      foreach (mv[k]) mv[k] = 1'b0;
      mhold = 0;
      return;
    end
    foreach (nv[k]) begin nv[k] = 1'b0; nd[k] = md[k]; end
    for (int k = 0; k < D; k++) begin
      if (mv[k] && !mmove[k]) begin nv[k] = 1'b1; nd[k] = md[k]; end
      else if (mv[k] && k < D-1) begin nv[k+1] = 1'b1; nd[k+1] = md[k]; end
    end
    if (mmove[D-1]) begin ret_q.push_back(md[D-1]); ret_t.push_back(cyc_n); end
    if (last_acc) begin
      nv[0] = 1'b1; nd[0] = bus.in_data; acc_t.push_back(cyc_n);
    end
    if (last_acc && bus.in_data[W-1 -: 4] == 4'hF) mhold = 3;
    else if (mhold > 0) mhold--;
    mv = nv; md = nd;
  endtask

  task automatic cyc(bit iv, logic [W-1:0] id, bit ordy, bit es, bit fl);
    bit mbusy;
    bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    ext_stall = es; flush = fl;
    @(negedge clk);
    model_eval();
    mbusy = 1'b0;
    foreach (mv[k]) mbusy |= mv[k];
    chk("in_ready", bus.in_ready, m_inrdy);
    chk("out_valid", bus.out_valid, m_ovld);
    chk("busy", busy, mbusy);
    chk("stall_count", stall_count, mcnt);
    if (m_ovld) chk("out_data", bus.out_data, md[D-1]);
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic do_reset(bit es);
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    ext_stall = es; flush = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_in_ready", bus.in_ready, !es);
    rst = 1'b0; ext_stall = 1'b0;
    clear_logs();
  endtask

  initial begin
    int idx;
    logic [W-1:0] r;
    cyc_n = 0;
    model_clear();

    do_reset(1'b1);

    // Streaming 0x11..0x18
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cyc(1, 32'h11 + idx, 1, 0, 0);
      if (last_acc) idx++;
    end
    chk("stream_sent", idx, 8);
    repeat (6) cyc(0, 0, 1, 0, 0);
    chk("stream_n", ret_q.size(), 8);
    if (ret_q.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("stream_order", ret_q[k], 32'h11 + k);
      chk("stream_latency", ret_t[0] - acc_t[0], D);
      chk("stream_tput", ret_t[7] - ret_t[0], 7);
    end
    chk("stream_stall", stall_count, 0);

    // Back-pressure: out_ready low for the first 9 cycles
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cyc(1, 32'h21 + idx, c >= 9, 0, 0);
      if (last_acc) idx++;
    end
    repeat (6) cyc(0, 0, 1, 0, 0);
    chk("bp_n", ret_q.size(), 8);
    if (ret_q.size() == 8)
      for (int k = 0; k < 8; k++) chk("bp_order", ret_q[k], 32'h21 + k);
    chk("bp_stall", stall_count, 5);

    // Multi-cycle hold
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 2; c++) begin
      cyc(1, idx == 0 ? 32'hF000_0001 : 32'h0000_0002, 1, 0, 0);
      if (last_acc) idx++;
    end
    repeat (10) cyc(0, 0, 1, 0, 0);
    chk("hold_n", ret_q.size(), 2);
    if (ret_q.size() == 2) begin
      chk("hold_first", ret_q[0], 32'hF000_0001);
      chk("hold_second", ret_q[1], 32'h0000_0002);
      chk("hold_latency", ret_t[0] - acc_t[0], D + 3);
      chk("hold_accept_gap", acc_t[1] - acc_t[0], 4);
      chk("hold_retire_gap", ret_t[1] - ret_t[0], 1);
    end
    chk("hold_stall", stall_count, 3);

    // ext_stall for two cycles mid-stream
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cyc(1, 32'h31 + idx, 1, c == 3 || c == 4, 0);
      if (last_acc) idx++;
    end
    repeat (6) cyc(0, 0, 1, 0, 0);
    chk("es_n", ret_q.size(), 8);
    if (ret_q.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("es_order", ret_q[k], 32'h31 + k);
      chk("es_span", ret_t[7] - ret_t[0], 9);
    end
    chk("es_stall", stall_count, 2);

    // Flush with a held STALL_OP in S0
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cyc(1, idx == 3 ? 32'hF000_0044 : 32'h41 + idx, 0, 0, 0);
      if (last_acc) idx++;
    end
    chk("flush_filled", idx, 4);
    cyc(1, 32'h99, 1, 0, 1);
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_no_retire", ret_q.size(), 0);
    clear_logs();
    idx = 0;
    for (int c = 0; c < 20 && idx < 1; c++) begin
      cyc(1, 32'h45, 1, 0, 0);
      if (last_acc) idx++;
    end
    repeat (6) cyc(0, 0, 1, 0, 0);
    chk("flush_next_n", ret_q.size(), 1);
    if (ret_q.size() == 1) begin
      chk("flush_next_data", ret_q[0], 32'h45);
      chk("flush_next_latency", ret_t[0] - acc_t[0], D);
    end

    // Counter saturation, then asynchronous reset between edges
    do_reset(1'b0);
    repeat (24) cyc(1, $urandom & 32'h0FFF_FFFF, 0, 0, 0);
    chk("sat_count", stall_count, 15);
    chk("sat_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_stall_count", stall_count, 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      if ($urandom_range(3) == 0) r[W-1 -: 4] = 4'hF;
      cyc($urandom_range(9) < 7, r, $urandom_range(9) < 7,
          $urandom_range(6) == 0, $urandom_range(31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
